ser_arbiter: RTL and testbench

- Shares one serializer between N independent L-bit word producers (e.g. parallel Toeplitz hash lanes).
- Grants requesters round-robin, loads the winner's word with a one-cycle qstrobe, then holds off until the serializer has emitted L qbiten-qualified bits.
- Tags each bit stream with its source index so downstream logic can demultiplex.

---
 rtl/ser_arb_pkg.sv | 20 ++
 rtl/ser_arbiter_rr.sv | 35 +++
 rtl/ser_arbiter.sv | 139 +++++++++++++
 tb/tb_ser_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_arb_pkg.sv
// Shared types and width helpers for the serializer arbiter.
package ser_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, BUSY waits for the serializer to drain a word.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bit counter must be able to hold the value L.
  function automatic int cnt_w(input int l);
    return $clog2(l + 1);
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_arbiter_rr.sv
// Combinational round-robin pick: scans upward from ptr+1 (mod N) and returns
// the first set request as a one-hot grant plus its index. The pointer itself
// lives in the parent so this block stays stateless.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Rotating-priority scan with explicit wrap so non-power-of-two N never
  // produces an index of N or above.
  always_comb begin
    logic [IW:0] pos;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (en && !found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        gnt[pos[IW-1:0]]     = 1'b1;
        gnt_idx              = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// ser_arbiter: shares one L-bit serializer between N word producers.
// Round-robin grant, one-cycle ack/qstrobe load, then waits for L qbiten
// pulses before arbitrating again. ser_src tags the stream owner.
// Optional feature macro: SER_ARB_TIMEOUT_EN adds an err port and aborts a
// word that has not completed TMO cycles after its qstrobe.
//
// Handshake: a requester holds req and data stable until it samples ack high;
// ack is a one-cycle pulse meaning data was captured. Keeping req high after
// ack asks for another word; dropping req before ack withdraws the request.
module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int L   = 8,
  parameter int N   = 4,
  parameter int TMO = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*L-1:0]        data,
  output logic [N-1:0]          ack,
  output logic [L-1:0]          ser_q,
  output logic                  ser_qstrobe,
  input  logic                  ser_qbiten,
  output logic [idx_w(N)-1:0]   ser_src,
  output logic                  busy,
  output logic                  word_done,
`ifdef SER_ARB_TIMEOUT_EN
  output logic                  err,
`endif
  output state_t                state_dbg
);

  localparam int IW = idx_w(N);
  localparam int CW = cnt_w(L);

  if (N < 2 || L < 1 || TMO < 1) begin : g_bad_params
    $error("ser_arbiter: needs N >= 2, L >= 1, TMO >= 1");
  end

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   bitcnt;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic [L-1:0]    win_word;

`ifdef SER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0]   tmo_cnt;
`endif

  assign state_dbg = state;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .en      (state == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Select the winning requester's word using the one-hot grant.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) win_word = data[i*L +: L];
    end
  end

  // Arbitration / drain FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IW'(N - 1);
      bitcnt      <= '0;
      ack         <= '0;
      ser_q       <= '0;
      ser_qstrobe <= 1'b0;
      ser_src     <= '0;
      busy        <= 1'b0;
      word_done   <= 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err         <= 1'b0;
`endif
    end else begin
      ack         <= '0;
      ser_qstrobe <= 1'b0;
      word_done   <= 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            ack         <= gnt;
            ser_qstrobe <= 1'b1;
            ser_q       <= win_word;
            ser_src     <= gnt_idx;
            busy        <= 1'b1;
            ptr         <= gnt_idx;
            bitcnt      <= '0;
            state       <= BUSY;
`ifdef SER_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        BUSY: begin
`ifdef SER_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (ser_qbiten) begin
            bitcnt <= bitcnt + 1'b1;
          end
          if (ser_qbiten && bitcnt == CW'(L - 1)) begin
            word_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`ifdef SER_ARB_TIMEOUT_EN
          // Completion on the same edge wins over the timeout.
          else if (tmo_cnt == TW'(TMO - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_arbiter.sv
// Directed testbench for ser_arbiter (L=8, N=4, TMO=16) plus an N=3 instance.
module tb_ser_arbiter;
  import ser_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic [7:0]  ser_q;
  logic        ser_qstrobe;
  logic        ser_qbiten = 1'b0;
  logic [1:0]  ser_src;
  logic        busy;
  logic        word_done;
  state_t      state_dbg;
`ifdef SER_ARB_TIMEOUT_EN
  logic        err;
`endif

  logic [2:0]  req3 = '0;
  logic [23:0] data3 = '0;
  logic [2:0]  ack3;
  logic [7:0]  ser_q3;
  logic        ser_qstrobe3;
  logic        ser_qbiten3 = 1'b0;
  logic [1:0]  ser_src3;
  logic        busy3;
  logic        word_done3;
  state_t      state_dbg3;
`ifdef SER_ARB_TIMEOUT_EN
  logic        err3;
`endif

  int errors = 0;
  int checks = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  ser_arbiter #(.L(8), .N(4), .TMO(16)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack),
    .ser_q(ser_q), .ser_qstrobe(ser_qstrobe), .ser_qbiten(ser_qbiten),
    .ser_src(ser_src), .busy(busy), .word_done(word_done),
`ifdef SER_ARB_TIMEOUT_EN
    .err(err),
`endif
    .state_dbg(state_dbg)
  );

  ser_arbiter #(.L(8), .N(3), .TMO(64)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .data(data3), .ack(ack3),
    .ser_q(ser_q3), .ser_qstrobe(ser_qstrobe3), .ser_qbiten(ser_qbiten3),
    .ser_src(ser_src3), .busy(busy3), .word_done(word_done3),
`ifdef SER_ARB_TIMEOUT_EN
    .err(err3),
`endif
    .state_dbg(state_dbg3)
  );

  // Driver: one qbiten-high cycle on the 4-way DUT, returns at the next negedge.
  task automatic send_bit();
    ser_qbiten = 1'b1;
    @(negedge clk);
    ser_qbiten = 1'b0;
  endtask

  task automatic send_bit3();
    ser_qbiten3 = 1'b1;
    @(negedge clk);
    ser_qbiten3 = 1'b0;
  endtask

  // Driver: wait (bounded) for a qstrobe on the 4-way DUT.
  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (ser_qstrobe === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_strobe3(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (ser_qstrobe3 === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack, ser_q, ser_qstrobe, ser_src, busy, word_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b q=%h stb=%b src=%0d busy=%b done=%b, want all 0",
               ack, ser_q, ser_qstrobe, ser_src, busy, word_done);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want IDLE", state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ser_qstrobe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got stb=%b busy=%b want 0 0", ser_qstrobe, busy);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    data = 32'h0000_0069;
    req  = 4'b0001;
    wait_strobe(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_strobe_timeout: got no qstrobe want qstrobe");
    end
    checks++;
    if (ack !== 4'b0001 || ser_q !== 8'h69 || ser_src !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got ack=%b q=%h src=%0d busy=%b want 0001 69 0 1",
               ack, ser_q, ser_src, busy);
    end
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      send_bit();
      checks++;
      if (i < 7) begin
        if (busy !== 1'b1 || word_done !== 1'b0 || ack !== 4'b0000 || ser_qstrobe !== 1'b0) begin
          errors++;
          $display("FAIL single_bit%0d: got busy=%b done=%b ack=%b stb=%b want 1 0 0000 0",
                   i, busy, word_done, ack, ser_qstrobe);
        end
      end else if (busy !== 1'b0 || word_done !== 1'b1) begin
        errors++;
        $display("FAIL single_done: got busy=%b done=%b want 0 1", busy, word_done);
      end
    end
    @(negedge clk);
    checks++;
    if (word_done !== 1'b0 || ser_qstrobe !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got done=%b stb=%b want 0 0", word_done, ser_qstrobe);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_q[$];
    logic [7:0] words [4];
    logic [1:0] g;
    bit ok;
    words = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    // last grant in the previous test was 0, so the rotation starts at 1
    data = {words[3], words[2], words[1], words[0]};
    req  = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      g = exp_q.pop_front();
      wait_strobe(ok);
      checks++;
      if (!ok || ack !== (4'b0001 << g) || ser_src !== g || ser_q !== words[g]) begin
        errors++;
        $display("FAIL rr_grant%0d: got ok=%0d ack=%b src=%0d q=%h want ack=%b src=%0d q=%h",
                 w, ok, ack, ser_src, ser_q, 4'b0001 << g, g, words[g]);
      end
      if (w == 4) req = 4'b0000;
      for (int i = 0; i < 8; i++) begin
        if (ser_src !== g || ser_qstrobe !== (i == 0 ? 1'b1 : 1'b0)) begin
          checks++;
          errors++;
          $display("FAIL rr_stream%0d_bit%0d: got src=%0d stb=%b want src=%0d", w, i,
                   ser_src, ser_qstrobe, g);
        end
        send_bit();
      end
      checks++;
      if (word_done !== 1'b1) begin
        errors++;
        $display("FAIL rr_done%0d: got %b want 1", w, word_done);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    data = {8'h00, 8'h00, 8'h3C, 8'h00};
    req  = 4'b0010;
    wait_strobe(ok);
    checks++;
    if (!ok || ack !== 4'b0010 || ser_src !== 2'd1 || ser_q !== 8'h3C) begin
      errors++;
      $display("FAIL stall_grant: got ok=%0d ack=%b src=%0d q=%h want 0010 1 3c",
               ok, ack, ser_src, ser_q);
    end
    req  = 4'b0000;
    data = '0;
    for (int i = 0; i < 3; i++) send_bit();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || word_done !== 1'b0 || ser_q !== 8'h3C || ser_src !== 2'd1) begin
        errors++;
        $display("FAIL stall_hold%0d: got busy=%b done=%b q=%h src=%0d want 1 0 3c 1",
                 s, busy, word_done, ser_q, ser_src);
      end
    end
    for (int i = 3; i < 8; i++) begin
      send_bit();
      checks++;
      if (word_done !== (i == 7 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL stall_bit%0d: got done=%b want %b", i, word_done, i == 7);
      end
    end
  endtask

  task automatic test_npot2();
    logic [1:0] exp [5];
    bit ok;
    exp   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    data3 = {8'h33, 8'h22, 8'h11};
    req3  = 3'b111;
    for (int w = 0; w < 5; w++) begin
      wait_strobe3(ok);
      checks++;
      if (!ok || ser_src3 !== exp[w] || ack3 !== (3'b001 << exp[w])) begin
        errors++;
        $display("FAIL npot_grant%0d: got ok=%0d src=%0d ack=%b want src=%0d", w, ok,
                 ser_src3, ack3, exp[w]);
      end
      if (w == 4) req3 = 3'b000;
      for (int i = 0; i < 8; i++) send_bit3();
    end
    checks++;
    if (word_done3 !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL npot_done: got done=%b busy=%b want 1 0", word_done3, busy3);
    end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    bit saw_done;
    data = 32'h0000_0069;
    req  = 4'b0001;
    wait_strobe(ok);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) send_bit();
    reset = 1'b1;
    #1;
    checks++;
    if ({ack, ser_q, ser_qstrobe, ser_src, busy, word_done} !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL midreset_clear: got q=%h src=%0d busy=%b done=%b st=%0d want all 0",
               ser_q, ser_src, busy, word_done, state_dbg);
    end
    saw_done = 1'b0;
    @(negedge clk);
    if (word_done === 1'b1) saw_done = 1'b1;
    reset = 1'b0;
    req   = 4'b0100;
    data  = {8'h00, 8'h5A, 8'h00, 8'h00};
    wait_strobe(ok);
    checks++;
    if (saw_done || !ok || ack !== 4'b0100 || ser_src !== 2'd2 || ser_q !== 8'h5A) begin
      errors++;
      $display("FAIL midreset_regrant: got done_seen=%0d ok=%0d ack=%b src=%0d q=%h want 0 1 0100 2 5a",
               saw_done, ok, ack, ser_src, ser_q);
    end
    req = 4'b0000;
    for (int i = 0; i < 8; i++) send_bit();
    checks++;
    if (word_done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_done: got %b want 1", word_done);
    end
  endtask

`ifdef SER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    req  = 4'b1111;
    data = 32'h44332211;
    wait_strobe(ok);
    checks++;
    if (!ok || ack !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_grant: got ok=%0d ack=%b want 1000", ok, ack);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (k < 16) begin
        if (err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL tmo_wait%0d: got err=%b busy=%b want 0 1", k, err, busy);
        end
      end else if (err !== 1'b1 || busy !== 1'b0 || word_done !== 1'b0) begin
        errors++;
        $display("FAIL tmo_err: got err=%b busy=%b done=%b want 1 0 0", err, busy, word_done);
      end
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || ser_qstrobe !== 1'b1 || ack !== 4'b0001) begin
      errors++;
      $display("FAIL tmo_next: got err=%b stb=%b ack=%b want 0 1 0001", err, ser_qstrobe, ack);
    end
    req = 4'b0000;
    for (int i = 0; i < 8; i++) send_bit();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_stall();
    test_npot2();
    test_reset_mid_word();
`ifdef SER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
